// File: rtl/operand_fetch.sv
// Operand-fetch / register-read stage.
//
// Takes one decoded instruction at a time from decode and holds it until its
// sources are hazard-free. It then reads both operands from the architectural
// register file, bypassing any writeback that retires in the same cycle, and
// presents them to execute over a valid/ready handshake. A per-register
// pending-write scoreboard tracks destination writes that have been issued to
// execute but have not yet come back through writeback.
//
// Ports:
//   clk_i, reset_i         clock; asynchronous active-high reset
//   regx_i                 16 x 64-bit architectural register file contents
//   in_*                   decode handshake plus source/destination fields
//   wb_*                   writeback retire port (valid, index, data)
//   out_*                  execute handshake, operands and destination
//   err_spurious_wb_o      sticky flag: writeback to a register with no pending write
module operand_fetch #(
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [15:0][63:0] regx_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        in_src1_i,
  input  logic              in_src1_en_i,
  input  logic [3:0]        in_src2_i,
  input  logic              in_src2_en_i,
  input  logic [3:0]        in_dst_i,
  input  logic              in_dst_en_i,
  input  logic              wb_valid_i,
  input  logic [3:0]        wb_reg_i,
  input  logic [63:0]       wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [63:0]       out_op1_o,
  output logic [63:0]       out_op2_o,
  output logic [3:0]        out_dst_o,
  output logic              out_dst_en_o,
  output logic              err_spurious_wb_o
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  typedef enum logic [1:0] {StEmpty, StWait, StFull} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [16];
  logic [CNT_W-1:0]  cnt_d [16];

  // Instruction slot (the instruction waiting for its hazards to clear).
  logic [3:0]  src1_q, src2_q, dst_q;
  logic        src1_en_q, src2_en_q, dst_en_q;

  // Registered execute-side outputs.
  logic [63:0] op1_q, op2_q, op1_d, op2_d;
  logic [3:0]  out_dst_q;
  logic        out_dst_en_q;
  logic        err_q, err_d;

  logic        wb_hit1, wb_hit2;
  logic        src1_clr, src2_clr, dst_ok;
  logic        issue, fire, accept;

  assign wb_hit1 = wb_valid_i & (wb_reg_i == src1_q);
  assign wb_hit2 = wb_valid_i & (wb_reg_i == src2_q);

  // A source with exactly one pending write is clear if that write retires
  // this cycle; the operand is then taken from the bypass.
  assign src1_clr = !src1_en_q || (cnt_q[src1_q] == '0) || ((cnt_q[src1_q] == CntOne) && wb_hit1);
  assign src2_clr = !src2_en_q || (cnt_q[src2_q] == '0) || ((cnt_q[src2_q] == CntOne) && wb_hit2);
  assign dst_ok   = !dst_en_q || (cnt_q[dst_q] != CntMax);

  assign issue  = (state_q == StWait) && src1_clr && src2_clr && dst_ok;
  assign fire   = (state_q == StFull) && out_ready_i;
  assign in_ready_o = !reset_i && ((state_q == StEmpty) || fire);
  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    op1_d = '0;
    op2_d = '0;
    if (src1_en_q) op1_d = wb_hit1 ? wb_data_i : regx_i[src1_q];
    if (src2_en_q) op2_d = wb_hit2 ? wb_data_i : regx_i[src2_q];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StWait;
      StWait:  if (issue)  state_d = StFull;
      StFull:  if (fire)   state_d = in_valid_i ? StWait : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Scoreboard: fire increments the destination, writeback decrements its
  // register; both on the same register cancel out.
  always_comb begin
    for (int unsigned r = 0; r < 16; r++) begin
      logic inc, dec;
      inc = fire && out_dst_en_q && (out_dst_q == 4'(r));
      dec = wb_valid_i && (wb_reg_i == 4'(r)) && (cnt_q[r] != '0);
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec && !inc) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
    end
    err_d = err_q || (wb_valid_i && (cnt_q[wb_reg_i] == '0));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StEmpty;
      err_q        <= 1'b0;
      src1_q       <= '0;
      src2_q       <= '0;
      dst_q        <= '0;
      src1_en_q    <= 1'b0;
      src2_en_q    <= 1'b0;
      dst_en_q     <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      out_dst_q    <= '0;
      out_dst_en_q <= 1'b0;
      for (int unsigned r = 0; r < 16; r++) cnt_q[r] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      for (int unsigned r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
      if (accept) begin
        src1_q    <= in_src1_i;
        src1_en_q <= in_src1_en_i;
        src2_q    <= in_src2_i;
        src2_en_q <= in_src2_en_i;
        dst_q     <= in_dst_i;
        dst_en_q  <= in_dst_en_i;
      end
      if (issue) begin
        op1_q        <= op1_d;
        op2_q        <= op2_d;
        out_dst_q    <= dst_q;
        out_dst_en_q <= dst_en_q;
      end
    end
  end

  assign out_valid_o       = (state_q == StFull);
  assign out_op1_o         = op1_q;
  assign out_op2_o         = op2_q;
  assign out_dst_o         = out_dst_q;
  assign out_dst_en_o      = out_dst_en_q;
  assign err_spurious_wb_o = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level scoreboard model.
module tb_operand_fetch;

  localparam int CntMax = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [15:0][63:0] regx;
  logic              in_valid, in_ready, in_src1_en, in_src2_en, in_dst_en;
  logic [3:0]        in_src1, in_src2, in_dst;
  logic              wb_valid;
  logic [3:0]        wb_reg;
  logic [63:0]       wb_data;
  logic              out_valid, out_ready, out_dst_en, err_spurious_wb;
  logic [63:0]       out_op1, out_op2;
  logic [3:0]        out_dst;

  operand_fetch #(.CNT_W(2)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .regx_i           (regx),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_src1_i        (in_src1),
    .in_src1_en_i     (in_src1_en),
    .in_src2_i        (in_src2),
    .in_src2_en_i     (in_src2_en),
    .in_dst_i         (in_dst),
    .in_dst_en_i      (in_dst_en),
    .wb_valid_i       (wb_valid),
    .wb_reg_i         (wb_reg),
    .wb_data_i        (wb_data),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_op1_o        (out_op1),
    .out_op2_o        (out_op2),
    .out_dst_o        (out_dst),
    .out_dst_en_o     (out_dst_en),
    .err_spurious_wb_o(err_spurious_wb)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a held instruction (waiting or presented), plus a count
  // of outstanding writes per register.
  int          pend_m [16];
  bit          waiting_m, presented_m, err_m;
  logic [3:0]  s1_m, s2_m, d_m, od_m;
  bit          s1e_m, s2e_m, de_m, ode_m;
  logic [63:0] op1_m, op2_m;

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 0;
    waiting_m = 0; presented_m = 0; err_m = 0;
    op1_m = '0; op2_m = '0; od_m = '0; ode_m = 0;
  endtask

  function automatic bit model_ready();
    return !reset && ((!waiting_m && !presented_m) || (presented_m && out_ready));
  endfunction

  function automatic bit src_ready(input bit en, input logic [3:0] s);
    return !en || pend_m[s] == 0 || (pend_m[s] == 1 && wb_valid && wb_reg == s);
  endfunction

  function automatic logic [63:0] read_op(input bit en, input logic [3:0] s);
    if (!en) return 64'd0;
    if (wb_valid && wb_reg == s) return wb_data;
    return regx[s];
  endfunction

  task automatic model_step();
    int  nxt [16];
    bit  take, go, done;
    take = in_valid && model_ready();
    done = presented_m && out_ready;
    go   = waiting_m && src_ready(s1e_m, s1_m) && src_ready(s2e_m, s2_m)
           && (!de_m || pend_m[d_m] < CntMax);
    foreach (nxt[i]) nxt[i] = pend_m[i];
    if (wb_valid) begin
      if (pend_m[wb_reg] == 0) err_m = 1;
      else nxt[wb_reg] = nxt[wb_reg] - 1;
    end
    if (done && ode_m) nxt[od_m] = nxt[od_m] + 1;
    if (go) begin
      op1_m = read_op(s1e_m, s1_m);
      op2_m = read_op(s2e_m, s2_m);
      od_m = d_m; ode_m = de_m;
      waiting_m = 0; presented_m = 1;
    end
    if (done) presented_m = 0;
    if (take) begin
      s1_m = in_src1; s1e_m = in_src1_en; s2_m = in_src2; s2e_m = in_src2_en;
      d_m = in_dst; de_m = in_dst_en; waiting_m = 1;
    end
    foreach (nxt[i]) pend_m[i] = nxt[i];
  endtask

  task automatic check_all();
    logic [63:0] cobs, cexp;
    cobs = '0; cexp = '0;
    for (int i = 0; i < 16; i++) begin
      cobs[i*2 +: 2] = dut.cnt_q[i];
      cexp[i*2 +: 2] = 2'(pend_m[i]);
    end
    check_eq("in_ready", 64'(in_ready), 64'(model_ready()));
    check_eq("out_valid", 64'(out_valid), 64'(presented_m));
    check_eq("out_op1", out_op1, op1_m);
    check_eq("out_op2", out_op2, op2_m);
    check_eq("out_dst", 64'(out_dst), 64'(od_m));
    check_eq("out_dst_en", 64'(out_dst_en), 64'(ode_m));
    check_eq("err_spurious_wb", 64'(err_spurious_wb), 64'(err_m));
    check_eq("pending_counts", cobs, cexp);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    #1;
    check_all();
    if (!reset) model_step();
    @(posedge clk);
    if (reset) model_reset();
    @(negedge clk);
  endtask

  task automatic set_op(input bit v, input logic [3:0] s1, input bit e1, input logic [3:0] s2,
                        input bit e2, input logic [3:0] d, input bit de);
    in_valid = v; in_src1 = s1; in_src1_en = e1; in_src2 = s2; in_src2_en = e2;
    in_dst = d; in_dst_en = de;
  endtask

  task automatic wb(input bit v, input logic [3:0] r, input logic [63:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  logic [63:0] held;
  int          pend_q [$];

  initial begin
    for (int i = 0; i < 16; i++) regx[i] = {$urandom, $urandom};
    set_op(0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    out_ready = 1;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    reset = 0;

    // Independent op.
    regx[1] = 64'h11; regx[2] = 64'h22;
    set_op(1, 1, 1, 2, 1, 3, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("indep_valid", 64'(out_valid), 64'd1);
    check_eq("indep_op1", out_op1, 64'h11);
    check_eq("indep_op2", out_op2, 64'h22);
    tick();
    check_eq("indep_cnt3", 64'(dut.cnt_q[3]), 64'd1);

    // RAW stall resolved by a same-cycle writeback bypass.
    set_op(1, 3, 1, 0, 0, 0, 0);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    check_eq("raw_stall", 64'(out_valid), 64'd0);
    wb(1, 3, 64'hDEAD);
    tick();
    wb(0, 0, 0);
    check_eq("raw_valid", 64'(out_valid), 64'd1);
    check_eq("raw_bypass_op1", out_op1, 64'hDEAD);
    check_eq("raw_op2_unused", out_op2, 64'd0);
    check_eq("raw_cnt3", 64'(dut.cnt_q[3]), 64'd0);
    tick();

    // Saturation of R5.
    for (int k = 0; k < 3; k++) begin
      set_op(1, 0, 0, 0, 0, 5, 1);
      tick();
      set_op(0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();
    end
    check_eq("sat_cnt5_full", 64'(dut.cnt_q[5]), 64'd3);
    set_op(1, 0, 0, 0, 0, 5, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("sat_held", 64'(out_valid), 64'd0);
    end
    wb(1, 5, 64'h5);
    tick();
    wb(0, 0, 0);
    tick();
    check_eq("sat_issued", 64'(out_valid), 64'd1);
    tick();
    check_eq("sat_cnt5_back", 64'(dut.cnt_q[5]), 64'd3);
    wb(1, 5, 64'h5);
    repeat (3) tick();
    wb(0, 0, 0);

    // Backpressure, then fire and capture on the same edge.
    out_ready = 0;
    set_op(1, 1, 1, 2, 0, 6, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    held = out_op1;
    for (int k = 0; k < 4; k++) begin
      check_eq("bp_valid", 64'(out_valid), 64'd1);
      check_eq("bp_in_ready", 64'(in_ready), 64'd0);
      check_eq("bp_op1_stable", out_op1, held);
      tick();
    end
    out_ready = 1;
    set_op(1, 2, 1, 0, 0, 7, 1);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    check_eq("b2b_gap", 64'(out_valid), 64'd0);
    tick();
    check_eq("b2b_valid", 64'(out_valid), 64'd1);
    check_eq("b2b_op1", out_op1, regx[2]);
    tick();
    wb(1, 6, 64'h6);
    tick();
    wb(1, 7, 64'h7);
    tick();
    wb(0, 0, 0);

    // Spurious writeback, then fire and writeback on the same register.
    check_eq("err_clear", 64'(err_spurious_wb), 64'd0);
    wb(1, 9, 64'h9);
    tick();
    wb(0, 0, 0);
    check_eq("spur_err", 64'(err_spurious_wb), 64'd1);
    check_eq("spur_cnt9", 64'(dut.cnt_q[9]), 64'd0);
    for (int k = 0; k < 2; k++) begin
      set_op(1, 0, 0, 0, 0, 4, 1);
      tick();
      set_op(0, 0, 0, 0, 0, 0, 0);
      tick();
      if (k == 0) tick();
    end
    wb(1, 4, 64'h4);
    tick();
    wb(0, 0, 0);
    check_eq("simul_cnt4", 64'(dut.cnt_q[4]), 64'd1);

    // Async reset while an instruction waits on R4.
    set_op(1, 4, 1, 0, 0, 0, 0);
    tick();
    set_op(0, 0, 0, 0, 0, 0, 0);
    tick();
    #2 reset = 1;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_err", 64'(err_spurious_wb), 64'd0);
    check_eq("rst_cnt4", 64'(dut.cnt_q[4]), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 0;
    tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) regx[$urandom_range(0, 15)] = {$urandom, $urandom};
      set_op($urandom_range(0, 9) < 6, 4'($urandom_range(0, 7)), 1'($urandom),
             4'($urandom_range(0, 7)), 1'($urandom), 4'($urandom_range(0, 7)), 1'($urandom));
      out_ready = $urandom_range(0, 9) < 7;
      pend_q.delete();
      foreach (pend_m[i]) if (pend_m[i] > 0) pend_q.push_back(i);
      if (pend_q.size() > 0 && $urandom_range(0, 9) < 4)
        wb(1, 4'(pend_q[$urandom_range(0, pend_q.size() - 1)]), {$urandom, $urandom});
      else if ($urandom_range(0, 59) == 0)
        wb(1, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      else
        wb(0, 0, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read / operand-fetch stage: the reader side of the 64-bit, 16-entry architectural register file that the writeback stage writes.
- Accepts one decoded instruction at a time from decode and tracks in-flight destination writes in a per-register pending scoreboard.
- Holds the instruction until its sources are hazard-free, then reads both operands, bypassing same-cycle writeback data, and presents them to execute over a valid/ready handshake.

Parameters:
CNT_W, 2, width of each per-register pending-write counter (max in-flight writes per register = 2^CNT_W-1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
regx  input  16x64  architectural register file contents (RAX..R15, index 0..15)
in_valid  input  1  decode offers an instruction
in_ready  output  1  stage accepts instruction this cycle
in_src1  input  4  source 1 register index
in_src1_en  input  1  source 1 used
in_src2  input  4  source 2 register index
in_src2_en  input  1  source 2 used
in_dst  input  4  destination register index
in_dst_en  input  1  instruction writes in_dst
wb_valid  input  1  writeback retires a write this cycle
wb_reg  input  4  writeback destination index
wb_data  input  64  writeback value
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts
out_op1  output  64  source 1 value (0 if unused)
out_op2  output  64  source 2 value (0 if unused)
out_dst  output  4  destination index
out_dst_en  output  1  destination valid
err_spurious_wb  output  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset (async, active-high): state=EMPTY; all 16 counters=0; out_valid=0, out_op1=out_op2=0, out_dst=0, out_dst_en=0, err_spurious_wb=0; in_ready=0 while reset is high. Reset mid-operation discards the held instruction and all pending counts.
- States: EMPTY, WAIT, FULL.
- in_ready = (state==EMPTY) | (state==FULL & out_ready). An in_valid&in_ready edge captures src/dst fields into the slot; next state=WAIT.
- Source i is clear when it is unused, OR cnt[src]==0, OR (cnt[src]==1 & wb_valid & wb_reg==src).
- Issue condition in WAIT: both sources clear AND (!dst_en OR cnt[dst] < 2^CNT_W-1).
  - If met: at the edge latch operands, set out_valid=1, go to FULL.
  - If not met: stay in WAIT.
- Operand value when used: wb_data if wb_valid & wb_reg==src, else regx[src]. An unused operand latches 0.
- Minimum latency: capture edge to out_valid high = 1 cycle, i.e. a 2-cycle pipeline. No hazard check is repeated in FULL; outputs stay stable while out_valid & !out_ready.
- Fire = FULL & out_ready. On fire: if out_dst_en, cnt[out_dst]++. Next state=WAIT if in_valid (back-to-back accept), else EMPTY. out_valid drops unless the next state is FULL.
- WB: if wb_valid, cnt[wb_reg]-- when nonzero. If zero, count is unchanged and err_spurious_wb is set (sticky until reset).
- Same-cycle fire increment and wb decrement on the same register: net unchanged.
- Counters never overflow: saturation is blocked at issue, and only one instruction is held at a time.
- Self-dependency (src==dst) is legal: the count increments only at fire, after the read.

Test Plan:
- Independent op: regx[1]=0x11, regx[2]=0x22, src1=1, src2=2, dst=3 → out_valid 1 cycle after capture, op1=0x11, op2=0x22; cnt[3]=1 after fire.
- RAW stall: after the above fires, issue src1=3 → held in WAIT with out_valid=0; wb_valid, wb_reg=3, wb_data=0xDEAD → same edge issues, op1=0xDEAD via bypass; cnt[3]=0.
- Saturation (CNT_W=2): fire three writes to R5 without WB, then a fourth with dst=5 → stays in WAIT until one wb to R5, then issues; cnt[5] returns to 3.
- Back-to-back with backpressure: out_ready=0 for 4 cycles → outputs stable, in_ready=0; out_ready=1 with in_valid=1 → fire and capture on the same edge, next op out 1 cycle later.
- Spurious WB / simultaneous: wb to R9 with cnt=0 → err_spurious_wb=1, cnt[9]=0. Fire dst=4 while wb_reg=4 with cnt[4]=1 → cnt[4] stays 1.
- Async reset asserted in WAIT mid-cycle → immediately out_valid=0, in_ready=0; after release all counts 0, state EMPTY, err flag cleared.
